// File: rtl/ex_pkg.sv
// ----------------------------------------------------------------------------
// ex_pkg
// Types and constants shared by the EX-stage multiply/divide sequencer.
//   XLEN            : operand/result width (only 32 is supported)
//   muldiv_op_e     : RV32M funct3 encodings
//   muldiv_state_e  : sequencer FSM states
//   is_div()        : true for the four divide/remainder operations
// ----------------------------------------------------------------------------
package ex_pkg;

   localparam int XLEN = 32;

   typedef enum logic [2:0] {
      OP_MUL    = 3'b000,
      OP_MULH   = 3'b001,
      OP_MULHSU = 3'b010,
      OP_MULHU  = 3'b011,
      OP_DIV    = 3'b100,
      OP_DIVU   = 3'b101,
      OP_REM    = 3'b110,
      OP_REMU   = 3'b111
   } muldiv_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } muldiv_state_e;

   function automatic logic is_div(input muldiv_op_e op);
      return (op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU});
   endfunction

endpackage : ex_pkg

// File: rtl/ex_muldiv_seq_if.sv
// ----------------------------------------------------------------------------
// ex_muldiv_seq_if
// EX-stage <-> multiply/divide sequencer connection.
//   start  : EX instruction is an M-extension op (held while stalled)
//   funct3 : RV32M operation code
//   rs1    : operand A (dividend / multiplicand)
//   rs2    : operand B (divisor / multiplier)
//   flush  : abort any in-flight op
//   stall  : combinational pipeline hold request
//   done   : one-cycle result-valid pulse
//   result : 32-bit result, valid while done=1
// master = EX stage, slave = sequencer.
// ----------------------------------------------------------------------------
interface ex_muldiv_seq_if;

   logic                     start;
   logic [2:0]               funct3;
   logic [ex_pkg::XLEN-1:0]  rs1;
   logic [ex_pkg::XLEN-1:0]  rs2;
   logic                     flush;
   logic                     stall;
   logic                     done;
   logic [ex_pkg::XLEN-1:0]  result;

   modport master (
      output start, funct3, rs1, rs2, flush,
      input  stall, done, result
   );

   modport slave (
      input  start, funct3, rs1, rs2, flush,
      output stall, done, result
   );

endinterface : ex_muldiv_seq_if

// File: rtl/muldiv_core.sv
// ----------------------------------------------------------------------------
// muldiv_core
// Iterative datapath for RV32M. On load, operands are converted to unsigned
// magnitudes and the result sign is recorded. Each step performs one
// shift-add (multiply) or one restoring shift-subtract (divide) iteration.
// fix_result applies the recorded sign and selects the requested word.
//   clk, rst_n : clock, async active-low reset
//   load       : capture op and operands (accept cycle)
//   step       : perform one iteration
//   op         : operation to capture on load
//   rs1, rs2   : operands to capture on load
//   fix_result : signed-corrected, word-selected result (valid after 32 steps)
// Register use: hi:lo is the 64-bit product for multiply; for divide, hi is
// the partial remainder and lo shifts dividend bits out / quotient bits in.
// ----------------------------------------------------------------------------
module muldiv_core
   import ex_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             step,
   input  muldiv_op_e       op,
   input  logic [XLEN-1:0]  rs1,
   input  logic [XLEN-1:0]  rs2,
   output logic [XLEN-1:0]  fix_result
);

   muldiv_op_e       op_q;
   logic             neg_q;
   logic [XLEN-1:0]  hi_q;
   logic [XLEN-1:0]  lo_q;
   logic [XLEN-1:0]  opnd_q;

   logic             a_signed, b_signed;
   logic             a_neg, b_neg;
   logic [XLEN-1:0]  a_mag, b_mag;
   logic             res_neg;

   logic [XLEN:0]    mul_sum;
   logic [XLEN:0]    div_shift;
   logic             div_ok;
   logic [XLEN-1:0]  div_rem;

   logic [2*XLEN-1:0] prod_fixed;
   logic [XLEN-1:0]   quo_fixed;
   logic [XLEN-1:0]   rem_fixed;

   // NOTE: every variable written in always_comb gets a default first, so no
   // path through the case can leave it unassigned and infer a latch.
   always_comb begin
      a_signed = 1'b0;
      b_signed = 1'b0;
      unique case (op)
         OP_MULH, OP_DIV, OP_REM: begin
            a_signed = 1'b1;
            b_signed = 1'b1;
         end
         OP_MULHSU: a_signed = 1'b1;
         default: ;
      endcase
   end

   assign a_neg = a_signed & rs1[XLEN-1];
   assign b_neg = b_signed & rs2[XLEN-1];
   assign a_mag = a_neg ? (~rs1 + 1'b1) : rs1;
   assign b_mag = b_neg ? (~rs2 + 1'b1) : rs2;
   // Remainder takes the dividend's sign; everything else is the XOR.
   assign res_neg = (op == OP_REM) ? a_neg : (a_neg ^ b_neg);

   // Multiply: add the multiplicand when the current multiplier bit is set,
   // then shift the 65-bit {carry, hi, lo} right by one.
   assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);

   // Divide: shift the next dividend bit into the remainder and subtract the
   // divisor if it fits. The true difference is below 2^XLEN, so the
   // XLEN-bit wrapped subtraction is exact.
   assign div_shift = {hi_q, lo_q[XLEN-1]};
   assign div_ok    = div_shift[XLEN] | (div_shift[XLEN-1:0] >= opnd_q);
   assign div_rem   = div_shift[XLEN-1:0] - opnd_q;

   // NOTE: sequential state is updated with non-blocking assignments only, so
   // every register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q   <= OP_MUL;
         neg_q  <= 1'b0;
         hi_q   <= '0;
         lo_q   <= '0;
         opnd_q <= '0;
      end else if (load) begin
         op_q   <= op;
         neg_q  <= res_neg;
         hi_q   <= '0;
         lo_q   <= is_div(op) ? a_mag : b_mag;
         opnd_q <= is_div(op) ? b_mag : a_mag;
      end else if (step) begin
         if (is_div(op_q)) begin
            hi_q <= div_ok ? div_rem : div_shift[XLEN-1:0];
            lo_q <= {lo_q[XLEN-2:0], div_ok};
         end else begin
            hi_q <= mul_sum[XLEN:1];
            lo_q <= {mul_sum[0], lo_q[XLEN-1:1]};
         end
      end
   end

   assign prod_fixed = neg_q ? (~{hi_q, lo_q} + 1'b1) : {hi_q, lo_q};
   assign quo_fixed  = neg_q ? (~lo_q + 1'b1) : lo_q;
   assign rem_fixed  = neg_q ? (~hi_q + 1'b1) : hi_q;

   always_comb begin
      fix_result = prod_fixed[XLEN-1:0];
      unique case (op_q)
         OP_MUL:                      fix_result = prod_fixed[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: fix_result = prod_fixed[2*XLEN-1:XLEN];
         OP_DIV, OP_DIVU:             fix_result = quo_fixed;
         OP_REM, OP_REMU:             fix_result = rem_fixed;
         default: ;
      endcase
   end

endmodule : muldiv_core

// File: rtl/ex_muldiv_seq.sv
// ----------------------------------------------------------------------------
// ex_muldiv_seq
// Iterative RV32M multiply/divide sequencer beside the EX-stage ALU. Accepts
// one op, stalls the pipeline through 32 iterations plus a sign-fix cycle,
// then pulses done with a registered result. Divide-by-zero and signed
// overflow skip straight to DONE with a fixed result.
//   clk   : clock
//   rst_n : async active-low reset
//   bus   : ex_muldiv_seq_if.slave (start/funct3/rs1/rs2/flush in,
//           stall/done/result out)
// ----------------------------------------------------------------------------
module ex_muldiv_seq
   import ex_pkg::*;
#(
   parameter int XLEN = ex_pkg::XLEN
)(
   input  logic                clk,
   input  logic                rst_n,
   ex_muldiv_seq_if.slave      bus
);

   localparam int CNT_W = $clog2(XLEN);

   muldiv_state_e    state_q, state_d;
   logic [CNT_W-1:0] cnt_q;
   logic             done_q;
   logic [XLEN-1:0]  result_q;

   muldiv_op_e       op;
   logic             accept;
   logic             div_zero;
   logic             div_ovf;
   logic             fast;
   logic [XLEN-1:0]  fast_val;
   logic [XLEN-1:0]  core_result;

   assign op     = muldiv_op_e'(bus.funct3);
   assign accept = (state_q == IDLE) & bus.start & ~bus.flush;

   // Corner cases resolved without iterating.
   assign div_zero = is_div(op) & (bus.rs2 == '0);
   assign div_ovf  = (op inside {OP_DIV, OP_REM}) &
                     (bus.rs1 == {1'b1, {(XLEN-1){1'b0}}}) &
                     (bus.rs2 == '1);
   assign fast     = div_zero | div_ovf;

   always_comb begin
      fast_val = '0;
      if (div_zero) begin
         fast_val = (op inside {OP_REM, OP_REMU}) ? bus.rs1 : '1;
      end else if (div_ovf) begin
         fast_val = (op == OP_REM) ? '0 : {1'b1, {(XLEN-1){1'b0}}};
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (accept) state_d = fast ? DONE : CALC;
         CALC: if (cnt_q == CNT_W'(XLEN-1)) state_d = FIX;
         FIX:  state_d = DONE;
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (bus.flush) state_d = IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         done_q   <= 1'b0;
         result_q <= '0;
      end else begin
         state_q <= state_d;
         if (accept)                 cnt_q <= '0;
         else if (state_q == CALC)   cnt_q <= cnt_q + 1'b1;
         // done and result are registered on entry to DONE; a flush forces
         // state_d to IDLE, which suppresses both.
         done_q <= (state_d == DONE);
         if (state_d == DONE) begin
            result_q <= (state_q == IDLE) ? fast_val : core_result;
         end
      end
   end

   muldiv_core u_core (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (accept),
      .step       (state_q == CALC),
      .op         (op),
      .rs1        (bus.rs1),
      .rs2        (bus.rs2),
      .fix_result (core_result)
   );

   assign bus.stall  = accept | (state_q == CALC) | (state_q == FIX);
   assign bus.done   = done_q;
   assign bus.result = result_q;

endmodule : ex_muldiv_seq
